// File: rtl/fir_frame_streamer.sv
// fir_frame_streamer: serial-to-frame writer and frame-to-serial reader around a
// block FIR filter. Samples arrive on a valid/ready input, are packed into ibuf
// (which drives the filter input array), the filter is started, its output
// array is captured into obuf and streamed out with an end-of-frame marker.
// Optional build macro STREAMER_TIMEOUT_EN adds a WAIT watchdog and the
// sticky timeout_err output.
module fir_frame_streamer #(
    parameter int N  = 256,
    parameter int DW = 8
`ifdef STREAMER_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 1024
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    input  logic          m_ready,
    output logic          m_last,
    output logic          filt_start,
    input  logic          filt_rdy,
    output logic [DW-1:0] filt_in  [N],
    input  logic [DW-1:0] filt_out [N],
    output logic          busy,
    output logic [15:0]   frame_cnt
`ifdef STREAMER_TIMEOUT_EN
    ,
    output logic          timeout_err
`endif
);

    localparam int IW = $clog2(N);

    typedef enum logic [2:0] {
        S_FILL,
        S_START,
        S_WAIT,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   wr_idx_q;
    logic [IW-1:0]   rd_idx_q;
    logic [IW-1:0]   rd_idx_d;
    logic [DW-1:0]   ibuf_q [N];
    logic [DW-1:0]   obuf_q [N];
    logic            s_ready_q;
    logic            m_valid_q;
    logic [DW-1:0]   m_data_q;
    logic            m_last_q;
    logic            filt_start_q;
    logic            busy_q;
    logic [15:0]     frame_cnt_q;
    logic            ibuf_we;

`ifdef STREAMER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]   wait_cnt_q;
    logic            timeout_err_q;
    assign timeout_err = timeout_err_q;
`endif

    // s_ready_q is only ever high in FILL, so it alone qualifies the write.
    assign ibuf_we  = s_valid && s_ready_q;
    assign rd_idx_d = rd_idx_q + 1'b1;

    assign s_ready    = s_ready_q;
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_last     = m_last_q;
    assign filt_start = filt_start_q;
    assign busy       = busy_q;
    assign frame_cnt  = frame_cnt_q;

    // The filter input array is a direct view of the frame buffer.
    for (genvar gi = 0; gi < N; gi++) begin : g_filt_in
        assign filt_in[gi] = ibuf_q[gi];
    end

    // Input frame buffer: one sample written per accepted handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) ibuf_q[i] <= '0;
        end else if (ibuf_we) begin
            ibuf_q[wr_idx_q] <= s_data;
        end
    end

    // Output frame buffer: whole filter result captured in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) obuf_q[i] <= '0;
        end else if (state_q == S_CAPTURE) begin
            for (int i = 0; i < N; i++) obuf_q[i] <= filt_out[i];
        end
    end

    // Frame sequencer with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FILL;
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            s_ready_q    <= 1'b1;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_last_q     <= 1'b0;
            filt_start_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_cnt_q  <= '0;
`ifdef STREAMER_TIMEOUT_EN
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_FILL: begin
                    if (ibuf_we) begin
                        if (wr_idx_q == IW'(N - 1)) begin
                            wr_idx_q     <= '0;
                            state_q      <= S_START;
                            s_ready_q    <= 1'b0;
                            filt_start_q <= 1'b1;
                            busy_q       <= 1'b1;
                        end else begin
                            wr_idx_q <= wr_idx_q + 1'b1;
                        end
                    end
                end
                S_START: begin
                    filt_start_q <= 1'b0;
                    state_q      <= S_WAIT;
`ifdef STREAMER_TIMEOUT_EN
                    wait_cnt_q   <= '0;
`endif
                end
                S_WAIT: begin
                    if (filt_rdy) begin
                        state_q <= S_CAPTURE;
                    end
`ifdef STREAMER_TIMEOUT_EN
                    else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
                        // Give up on this frame: drop it and accept a new one.
                        timeout_err_q <= 1'b1;
                        state_q       <= S_FILL;
                        s_ready_q     <= 1'b1;
                        busy_q        <= 1'b0;
                        wr_idx_q      <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
`endif
                end
                S_CAPTURE: begin
                    // obuf is loading this cycle, so present element 0 straight from the filter.
                    state_q   <= S_DRAIN;
                    rd_idx_q  <= '0;
                    m_valid_q <= 1'b1;
                    m_data_q  <= filt_out[0];
                    m_last_q  <= (N == 1);
                end
                S_DRAIN: begin
                    if (m_ready) begin
                        if (m_last_q) begin
                            state_q     <= S_FILL;
                            rd_idx_q    <= '0;
                            m_valid_q   <= 1'b0;
                            m_last_q    <= 1'b0;
                            s_ready_q   <= 1'b1;
                            busy_q      <= 1'b0;
                            frame_cnt_q <= frame_cnt_q + 1'b1;
                        end else begin
                            rd_idx_q <= rd_idx_d;
                            m_data_q <= obuf_q[rd_idx_d];
                            m_last_q <= (rd_idx_d == IW'(N - 1));
                        end
                    end
                end
                default: begin
                    state_q <= S_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_frame_streamer.sv
// Testbench for fir_frame_streamer: randomized frames through a stub filter
// (out[i] = in[i] ^ 8'hFF), checked against a queue-based frame model.
module tb_fir_frame_streamer;

    localparam int N  = 256;
    localparam int DW = 8;
`ifdef STREAMER_TIMEOUT_EN
    localparam int TO = 16;
`endif

    logic          clk;
    logic          rst_n;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic          m_last;
    logic          filt_start;
    logic          filt_rdy;
    logic [DW-1:0] filt_in  [N];
    logic [DW-1:0] filt_out [N];
    logic          busy;
    logic [15:0]   frame_cnt;
`ifdef STREAMER_TIMEOUT_EN
    logic          timeout_err;
`endif

    fir_frame_streamer #(
        .N  (N),
        .DW (DW)
`ifdef STREAMER_TIMEOUT_EN
        ,
        .TIMEOUT (TO)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .filt_start (filt_start),
        .filt_rdy   (filt_rdy),
        .filt_in    (filt_in),
        .filt_out   (filt_out),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
`ifdef STREAMER_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Stub filter: computes on start, sticky ready.
    bit stub_rdy_en = 1'b1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_rdy <= 1'b0;
        end else if (filt_start) begin
            for (int i = 0; i < N; i++) filt_out[i] <= filt_in[i] ^ 8'hFF;
            if (stub_rdy_en) filt_rdy <= 1'b1;
        end
    end

    // Downstream sink with optional random backpressure.
    bit bp_en = 1'b0;
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = bp_en ? 1'($urandom_range(1)) : 1'b1;
        end
    end

    // Reference model: accepted samples form frames; each full frame yields
    // an expected output frame of in[i]^FF in index order.
    logic [7:0] in_q[$];
    logic [7:0] exp_q[$];
    bit         discard_frames = 1'b0;
    int cyc = 0, last_in_cyc = 0, first_in_cyc = 0, start_cyc = 0;
    int n_starts = 0, out_cnt = 0, frames_done = 0, last_out_cyc = 0;
    bit prev_stall = 1'b0, prev_valid = 1'b0, prev_last = 1'b0;
    logic [7:0] prev_data = '0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            in_q.delete();
            exp_q.delete();
            out_cnt = 0;
        end else begin
            if (s_valid && s_ready) begin
                if (in_q.size() == 0) first_in_cyc = cyc;
                in_q.push_back(s_data);
                if (in_q.size() == N) begin
                    last_in_cyc = cyc;
                    if (!discard_frames)
                        foreach (in_q[i]) exp_q.push_back(in_q[i] ^ 8'hFF);
                    in_q.delete();
                end
            end
            if (filt_start) begin
                n_starts++;
                check_eq("start_latency", cyc - last_in_cyc, 1);
                start_cyc = cyc;
            end
            if (m_valid) begin
                check_eq("s_ready_in_drain", s_ready, 0);
                if (!prev_valid) check_eq("first_out_latency", cyc - start_cyc, 3);
                if (prev_stall) begin
                    check_eq("stall_data_hold", m_data, prev_data);
                    check_eq("stall_last_hold", m_last, prev_last);
                end
                if (m_ready) begin
                    check_eq("out_available", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) check_eq("m_data", m_data, exp_q.pop_front());
                    check_eq("m_last", m_last, out_cnt == N - 1);
                    out_cnt++;
                    if (out_cnt == N) begin
                        out_cnt = 0;
                        frames_done++;
                        last_out_cyc = cyc;
                    end
                end
            end
        end
        prev_stall = m_valid && !m_ready;
        prev_valid = m_valid;
        prev_data  = m_data;
        prev_last  = m_last;
    end

    task automatic send_sample(input logic [7:0] d, input int gap_pct);
        if ($urandom_range(99) < gap_pct) begin
            s_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = d;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk);
                #1;
                s_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        check_eq("sample_accept_timeout", s_ready, 1);
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input int mode, input int gap_pct);
        for (int i = 0; i < N; i++)
            send_sample(mode == 0 ? 8'(i) : 8'($urandom), gap_pct);
    endtask

    task automatic wait_frames(input int target);
        for (int t = 0; t < 20000; t++) begin
            if (frames_done >= target) break;
            @(posedge clk);
        end
        if (frames_done < target) check_eq("frame_wait_timeout", frames_done, target);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int base;

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_s_ready", s_ready, 1);
        check_eq("rst_m_valid", m_valid, 0);
        check_eq("rst_m_last", m_last, 0);
        check_eq("rst_m_data", m_data, 0);
        check_eq("rst_filt_start", filt_start, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_frame_cnt", frame_cnt, 0);
        check_eq("rst_filt_in0", filt_in[0], 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Ramp frame, no gaps, no backpressure.
        base = frames_done;
        send_frame(0, 0);
        wait_frames(base + 1);
        check_eq("t1_frame_cnt", frame_cnt, 1);
        check_eq("t1_starts", n_starts, 1);
        check_eq("t1_total_latency", last_out_cyc - first_in_cyc, 2 * N + 2);
        check_eq("t1_busy_idle", busy, 0);
        check_eq("t1_s_ready_idle", s_ready, 1);
        $display("frame ramp done: frame_cnt=%0d", frame_cnt);

        // Random data, input gaps and output backpressure, two frames.
        bp_en = 1'b1;
        base  = frames_done;
        send_frame(1, 30);
        send_frame(1, 30);
        wait_frames(base + 2);
        bp_en = 1'b0;
        check_eq("t2_frame_cnt", frame_cnt, 3);
        $display("frames random/backpressure done: frame_cnt=%0d", frame_cnt);

        // Reset in the middle of a fill.
        for (int i = 0; i < 100; i++) send_sample(8'(i + 1), 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_filt_in0", filt_in[0], 0);
        check_eq("mid_rst_filt_in99", filt_in[99], 0);
        check_eq("mid_rst_frame_cnt", frame_cnt, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_m_valid", m_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        base = frames_done;
        send_frame(1, 10);
        wait_frames(base + 1);
        check_eq("t3_frame_cnt", frame_cnt, 1);
        $display("frame after mid-fill reset done: frame_cnt=%0d", frame_cnt);

        // Three back-to-back frames with sticky ready.
        do_reset();
        base = frames_done;
        for (int f = 0; f < 3; f++) send_frame(1, 0);
        wait_frames(base + 3);
        check_eq("t4_frame_cnt", frame_cnt, 3);
        $display("three back-to-back frames done: frame_cnt=%0d", frame_cnt);

`ifdef STREAMER_TIMEOUT_EN
        // Filter never ready: frame must be dropped after TO WAIT cycles.
        stub_rdy_en    = 1'b0;
        discard_frames = 1'b1;
        do_reset();
        send_frame(1, 0);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (timeout_err) break;
        end
        check_eq("to_err", timeout_err, 1);
        check_eq("to_latency", cyc - start_cyc, TO + 1);
        check_eq("to_s_ready", s_ready, 1);
        check_eq("to_busy", busy, 0);
        check_eq("to_frame_cnt", frame_cnt, 0);
        $display("timeout frame done: timeout_err=%0d", timeout_err);
`endif

        check_eq("leftover_expected", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
